h_shift_out16: RTL
==================

H_SHIFT_OUT16 -- requirements
Module: h_shift_out16

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk and rst, listed first.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_data, input, 16 bits: parallel word to transmit.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a word; high only in IDLE; combinational from state.
REQ-007 SHALL have port sout, output, 1 bit: serial data bit, registered.
REQ-008 SHALL have port sout_valid, output, 1 bit: sout carries a valid bit this cycle, registered.
REQ-009 SHALL have port busy, output, 1 bit: high in every non-IDLE state.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse after the last bit of a word, registered.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT and (with parity enabled) PAR.
REQ-012 SHALL accept a word on the clk edge where in_valid=1 and in_ready=1, latch in_data into a 16-bit shift register, and move to SHIFT.
REQ-013 SHALL ignore in_valid while not in IDLE; in_data changes after acceptance SHALL NOT affect the transmitted word.
REQ-014 SHALL, in SHIFT, present bits LSB first: cycle k after acceptance (k=1..16) has sout=word[k-1] and sout_valid=1.
REQ-015 SHALL count SHIFT bits with a 4-bit counter that wraps 15->0 on the last bit; leave SHIFT after exactly 16 bit-cycles.
REQ-016 SHALL hold sout=0 and sout_valid=0 whenever no bit is being presented.
REQ-017 SHALL, after the final bit cycle, return to IDLE and assert done=1 for exactly that first IDLE cycle.
REQ-018 SHALL allow acceptance of the next word during the done cycle; back-to-back throughput is one word per 17 cycles (18 with parity).
REQ-019 SHALL hold in_ready=0 and busy=1 throughout SHIFT and PAR.

Reset
REQ-020 SHALL, on rst=1, immediately force IDLE, shift register=0, counter=0, sout=0, sout_valid=0, done=0, busy=0; in_ready becomes 1.
REQ-021 SHALL, on reset during SHIFT or PAR, discard the word in flight and emit no done pulse.
REQ-022 SHALL accept a word on the first clk edge after rst deasserts, if in_valid=1.

Configuration
REQ-023 SHALL, when macro H_SHIFT_OUT16_PARITY_EN is defined, go SHIFT->PAR after bit 15, present the odd-parity bit (~^word) with sout_valid=1 for one cycle, then go to IDLE with done.
REQ-024 SHALL, without H_SHIFT_OUT16_PARITY_EN, omit the PAR state entirely; SHIFT goes directly to IDLE.

Verification
REQ-025 SHALL cover: reset, then accept 16'hA5C3 -> cycles 1..16 have sout=1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; done=1 at cycle 17.
REQ-026 SHALL cover: in_valid held high with 16'h0001 then 16'h8000 -> second word accepted in the done cycle; sout=1 on its 16th bit only.
REQ-027 SHALL cover: rst pulsed at cycle 8 of 16'hFFFF -> sout_valid=0 immediately, no done, in_ready=1.
REQ-028 SHALL cover: in_data changed to 16'h0000 and in_valid toggled during SHIFT of 16'h1234 -> transmitted bits still 16'h1234, in_ready=0.
REQ-029 SHALL cover, with H_SHIFT_OUT16_PARITY_EN: 16'h0003 -> 17th bit sout=1 and done at cycle 18; 16'h0007 -> 17th bit=0.

Source files
------------

// File: rtl/h_shift_out16.sv
// -----------------------------------------------------------------------------
// h_shift_out16
//   Parallel-to-serial transmitter for 16-bit words. A word is accepted while
//   the block is idle and then presented one bit per clock, LSB first, on a
//   registered sout/sout_valid pair. A one-cycle done pulse marks the first
//   idle cycle after the last bit, and the next word may be accepted in that
//   same cycle.
//
//   Optional feature: define H_SHIFT_OUT16_PARITY_EN to append an odd-parity
//   bit (~^word) after the 16 data bits.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   in_data    in   [15:0] parallel word to transmit
//   in_valid   in   in_data is valid this cycle
//   in_ready   out  block can accept a word (idle only), combinational
//   sout       out  serial data bit, registered
//   sout_valid out  sout carries a valid bit, registered
//   busy       out  high in every non-idle state
//   done       out  one-cycle pulse after the last bit, registered
// -----------------------------------------------------------------------------
module h_shift_out16 (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        sout,
   output logic        sout_valid,
   output logic        busy,
   output logic        done
);

`ifdef H_SHIFT_OUT16_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
   typedef enum logic {IDLE, SHIFT} state_t;
`endif

   state_t      state, state_nxt;
   logic [15:0] shreg, shreg_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        sout_nxt, sout_valid_nxt, done_nxt;
`ifdef H_SHIFT_OUT16_PARITY_EN
   logic        par_bit, par_nxt;
`endif

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   // State register and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         shreg      <= '0;
         cnt        <= '0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         done       <= 1'b0;
`ifdef H_SHIFT_OUT16_PARITY_EN
         par_bit    <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         shreg      <= shreg_nxt;
         cnt        <= cnt_nxt;
         sout       <= sout_nxt;
         sout_valid <= sout_valid_nxt;
         done       <= done_nxt;
`ifdef H_SHIFT_OUT16_PARITY_EN
         par_bit    <= par_nxt;
`endif
      end
   end

   // Next-state and next-output logic.
   // Bit 0 goes straight to sout at acceptance, so the shift register only
   // keeps the bits still to be sent; sout is always loaded from its LSB.
   always_comb begin
      state_nxt      = state;
      shreg_nxt      = shreg;
      cnt_nxt        = cnt;
      sout_nxt       = 1'b0;
      sout_valid_nxt = 1'b0;
      done_nxt       = 1'b0;
`ifdef H_SHIFT_OUT16_PARITY_EN
      par_nxt        = par_bit;
`endif
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_nxt      = SHIFT;
               shreg_nxt      = {1'b0, in_data[15:1]};
               cnt_nxt        = 4'd0;
               sout_nxt       = in_data[0];
               sout_valid_nxt = 1'b1;
`ifdef H_SHIFT_OUT16_PARITY_EN
               par_nxt        = ~^in_data;
`endif
            end
         end
         SHIFT: begin
            // cnt indexes the bit currently on sout; it wraps 15->0 as the
            // last bit leaves.
            cnt_nxt   = cnt + 4'd1;
            shreg_nxt = {1'b0, shreg[15:1]};
            if (cnt == 4'd15) begin
`ifdef H_SHIFT_OUT16_PARITY_EN
               state_nxt      = PAR;
               sout_nxt       = par_bit;
               sout_valid_nxt = 1'b1;
`else
               state_nxt      = IDLE;
               done_nxt       = 1'b1;
`endif
            end else begin
               sout_nxt       = shreg[0];
               sout_valid_nxt = 1'b1;
            end
         end
`ifdef H_SHIFT_OUT16_PARITY_EN
         PAR: begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

endmodule
